mem_arbiter: RTL

Non-preemptive arbiter sharing the single-port synchronous data memory between the CPU load/store path and the VGA line-buffer fetch engine. It grants one requester at a time and sequences the memory enable, write-enable and address. It returns read data to the owning requester. VGA bursts take priority over the CPU because of the display deadline; an optional starvation guard bounds CPU wait.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its two requesters plus the data memory.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        vga_done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        output cpu_rdata, cpu_ack, vga_data, vga_valid, vga_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        input  cpu_rdata, cpu_ack, vga_data, vga_valid, vga_done,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Non-preemptive CPU/VGA arbiter for the single-port data memory; VGA bursts have priority.
// Optional CPU starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
//
// state     | meaning
// IDLE      | no owner, grant decision made here
// CPU_RD    | CPU read strobe on the memory
// CPU_WAIT  | memory returning CPU read data
// CPU_WR    | CPU write strobe on the memory
// VGA_BURST | issuing BURST_LEN sequential reads
// VGA_DRAIN | collecting the remaining burst read data
module mem_arbiter #(
    parameter int BURST_LEN  = 8,
    parameter int STARVE_MAX = 2
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WAIT, CPU_WR, VGA_BURST, VGA_DRAIN} state_t;

    localparam logic [5:0] ISSUE_LAST = 6'(BURST_LEN - 1);
    localparam logic [6:0] RET_LAST   = 7'(BURST_LEN - 1);
    localparam logic [6:0] RET_FULL   = 7'(BURST_LEN);

    if (BURST_LEN < 2 || BURST_LEN > 64 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
        $error("mem_arbiter: BURST_LEN must be 2..64 and STARVE_MAX 1..7");
    end

    state_t      state, state_nxt;
    logic [5:0]  issue_cnt, issue_cnt_nxt;
    logic [6:0]  ret_cnt, ret_cnt_nxt;
    logic        rd_pend, rd_pend_nxt;
    logic [15:0] cpu_rdata_nxt, vga_data_nxt, mem_addr_nxt, mem_wdata_nxt;
    logic        cpu_ack_nxt, vga_valid_nxt, vga_done_nxt, mem_en_nxt, mem_we_nxt;

    // A requester is not re-granted in the cycle its own completion is visible.
    logic vga_elig, cpu_elig, cpu_first, grant_vga, grant_cpu;
    assign vga_elig  = bus.vga_req & ~bus.vga_done;
    assign cpu_elig  = bus.cpu_req & ~bus.cpu_ack;
    assign grant_vga = vga_elig & ~cpu_first;
    assign grant_cpu = cpu_elig & ~grant_vga;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (grant_cpu)
                starve_cnt <= 3'd0;
            else if (grant_vga && bus.cpu_req)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign cpu_first = cpu_elig & vga_elig & (starve_cnt == 3'(STARVE_MAX));
`else
    assign cpu_first = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            issue_cnt     <= 6'd0;
            ret_cnt       <= 7'd0;
            rd_pend       <= 1'b0;
            bus.cpu_rdata <= 16'h0000;
            bus.cpu_ack   <= 1'b0;
            bus.vga_data  <= 16'h0000;
            bus.vga_valid <= 1'b0;
            bus.vga_done  <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 16'h0000;
        end else begin
            state         <= state_nxt;
            issue_cnt     <= issue_cnt_nxt;
            ret_cnt       <= ret_cnt_nxt;
            rd_pend       <= rd_pend_nxt;
            bus.cpu_rdata <= cpu_rdata_nxt;
            bus.cpu_ack   <= cpu_ack_nxt;
            bus.vga_data  <= vga_data_nxt;
            bus.vga_valid <= vga_valid_nxt;
            bus.vga_done  <= vga_done_nxt;
            bus.mem_en    <= mem_en_nxt;
            bus.mem_we    <= mem_we_nxt;
            bus.mem_addr  <= mem_addr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        ret_cnt_nxt   = ret_cnt;
        rd_pend_nxt   = 1'b0;
        cpu_rdata_nxt = bus.cpu_rdata;
        cpu_ack_nxt   = 1'b0;
        vga_data_nxt  = bus.vga_data;
        vga_valid_nxt = 1'b0;
        vga_done_nxt  = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = bus.mem_addr;
        mem_wdata_nxt = bus.mem_wdata;

        case (state)
            IDLE: begin
                if (grant_vga) begin
                    state_nxt     = VGA_BURST;
                    mem_en_nxt    = 1'b1;
                    mem_addr_nxt  = bus.vga_addr;
                    issue_cnt_nxt = 6'd0;
                    ret_cnt_nxt   = 7'd0;
                end else if (grant_cpu) begin
                    state_nxt     = bus.cpu_we ? CPU_WR : CPU_RD;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = bus.cpu_we;
                    mem_addr_nxt  = bus.cpu_addr;
                    mem_wdata_nxt = bus.cpu_wdata;
                end
            end
            CPU_WR: begin
                state_nxt   = IDLE;
                cpu_ack_nxt = 1'b1;
            end
            CPU_RD: state_nxt = CPU_WAIT;
            CPU_WAIT: begin
                state_nxt     = IDLE;
                cpu_rdata_nxt = bus.mem_rdata;
                cpu_ack_nxt   = 1'b1;
            end
            VGA_BURST: begin
                // mem_en is high for every cycle spent here, so each one yields a return word.
                rd_pend_nxt = 1'b1;
                if (issue_cnt == ISSUE_LAST) begin
                    state_nxt = VGA_DRAIN;
                end else begin
                    mem_en_nxt    = 1'b1;
                    mem_addr_nxt  = bus.mem_addr + 16'd1;
                    issue_cnt_nxt = issue_cnt + 6'd1;
                end
            end
            VGA_DRAIN: begin
                if (ret_cnt == RET_FULL)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (rd_pend) begin
            vga_data_nxt  = bus.mem_rdata;
            vga_valid_nxt = 1'b1;
            vga_done_nxt  = (ret_cnt == RET_LAST);
            ret_cnt_nxt   = ret_cnt + 7'd1;
        end
    end
endmodule
